// File: rtl/run_controller.sv
// Sequencer: load an instruction stream into IMEM, run the datapath, dump the register file; RUN_CYCLE_COUNT_EN adds a cycle-count port and 33rd dump beat.
// Latency: an accepted load beat appears on the IMEM write port one cycle later; dp_start rises one cycle after the last write.
// Backpressure: load_valid/load_ready and dump_valid/dump_ready handshakes; ra and dump data hold while dump_ready is low.
module run_controller #(
    parameter int IMEM_DEPTH = 256,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_go_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [31:0] load_data_i,
    input  logic        load_last_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        dp_start_o,
    input  logic        done_in_i,
    output logic [4:0]  ra_o,
    input  logic [31:0] reg_data_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [31:0] dump_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o
`ifdef RUN_CYCLE_COUNT_EN
    ,
    output logic [31:0] cycle_count_o
`endif
);

`ifdef RUN_CYCLE_COUNT_EN
    localparam int NBEATS = 33;
`else
    localparam int NBEATS = 32;
`endif
    localparam int          WCW      = $clog2(IMEM_DEPTH) + 1;
    localparam logic [5:0]  LAST_IDX = 6'(NBEATS - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic            imem_we_q, imem_we_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [31:0]     imem_data_q, imem_data_d;
    logic [31:0]     cyc_q, cyc_d;
    logic            timeout_q, timeout_d;
    logic [5:0]      idx_q, idx_d;
    logic            dp_start_q, dp_start_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cyc_q       <= '0;
            timeout_q   <= 1'b0;
            idx_q       <= '0;
            dp_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cyc_q       <= cyc_d;
            timeout_q   <= timeout_d;
            idx_q       <= idx_d;
            dp_start_q  <= dp_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        cyc_d       = cyc_q;
        timeout_d   = timeout_q;
        idx_d       = idx_q;
        dp_start_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_go_i) begin
                    state_d     = S_LOAD;
                    wcnt_d      = '0;
                    imem_addr_d = '0;
                    cyc_d       = '0;
                    timeout_d   = 1'b0;
                    idx_d       = '0;
                end
            end
            S_LOAD: begin
                if (load_valid_i) begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = 32'({wcnt_q, 2'b00});
                    imem_data_d = load_data_i;
                    wcnt_d      = wcnt_q + WCW'(1);
                    if (load_last_i || (wcnt_q == WCW'(IMEM_DEPTH - 1))) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // dp_start is registered so it rises one cycle after the final IMEM write
                if (done_in_i) begin
                    state_d = S_DUMP;
                end else if (cyc_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DUMP;
                end else begin
                    cyc_d      = cyc_q + 32'd1;
                    dp_start_d = 1'b1;
                end
            end
            S_DUMP: begin
                if (dump_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dump_data_o = '0;
        if (state_q == S_DUMP) begin
`ifdef RUN_CYCLE_COUNT_EN
            dump_data_o = (idx_q == 6'd32) ? cyc_q : reg_data_i;
`else
            dump_data_o = reg_data_i;
`endif
        end
    end

    assign load_ready_o = (state_q == S_LOAD);
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_data_o  = imem_data_q;
    assign dp_start_o   = dp_start_q;
    assign ra_o         = idx_q[4:0];
    assign dump_valid_o = (state_q == S_DUMP);
    assign busy_o       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DUMP);
    assign done_o       = (state_q == S_DONE);
    assign timeout_o    = timeout_q;
`ifdef RUN_CYCLE_COUNT_EN
    assign cycle_count_o = cyc_q;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Randomized self-checking bench for run_controller against a transaction-level model of load/run/dump.
module tb_run_controller;
    localparam int DEPTH = 8;
    localparam int TO    = 24;
`ifdef RUN_CYCLE_COUNT_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_go = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic        done_in = 1'b0, dump_ready = 1'b0;
    logic [31:0] load_data = '0, reg_base = 32'h100;
    logic        load_ready, imem_we, dp_start, dump_valid, busy, done, timeout;
    logic [31:0] imem_addr, imem_data, dump_data, reg_data;
    logic [4:0]  ra;
`ifdef RUN_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    assign reg_data = reg_base + 32'(ra);

    run_controller #(.IMEM_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_go_i(cmd_go),
        .load_valid_i(load_valid), .load_ready_o(load_ready),
        .load_data_i(load_data), .load_last_i(load_last),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_data_o(imem_data),
        .dp_start_o(dp_start), .done_in_i(done_in),
        .ra_o(ra), .reg_data_i(reg_data),
        .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .dump_data_o(dump_data),
        .busy_o(busy), .done_o(done), .timeout_o(timeout)
`ifdef RUN_CYCLE_COUNT_EN
        , .cycle_count_o(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t         wr_obs[$];
    logic [31:0] prog[$];

    always @(negedge clk) if (imem_we === 1'b1) wr_obs.push_back('{imem_addr, imem_data});

    task automatic fill(input int n);
        prog.delete();
        repeat (n) prog.push_back($urandom);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_load_rdy"}, load_ready, 0);
        check({pfx, "_imem_we"}, imem_we, 0);
        check({pfx, "_imem_addr"}, imem_addr, 0);
        check({pfx, "_imem_data"}, imem_data, 0);
        check({pfx, "_dp_start"}, dp_start, 0);
        check({pfx, "_dump_vld"}, dump_valid, 0);
        check({pfx, "_dump_dat"}, dump_data, 0);
        check({pfx, "_ra"}, 32'(ra), 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_timeout"}, timeout, 0);
    endtask

    // Called just after a falling edge; reset takes effect mid-cycle, outputs checked before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst");
        wr_obs.delete();
        load_valid = 1'b1; dump_ready = 1'b1; cmd_go = 1'b0; done_in = 1'b0; load_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy", busy, 0);
            check("post_rst_load_rdy", load_ready, 0);
            check("post_rst_imem_we", imem_we, 0);
            check("post_rst_dp_start", dp_start, 0);
        end
        #1 check("post_rst_no_write", 32'(wr_obs.size()), 0);
        load_valid = 1'b0; dump_ready = 1'b0;
    endtask

    // lastpos: 1-based position of load_last (0 = none). d: RUN cycle (0 = first RUN cycle) on which done_in is high.
    task automatic run_episode(input int lastpos, input int d, input int stall_beat,
                               input int rst_mode, input int rst_at);
        int exp_n, x, i, b, guard, stall_left;
        logic to_exp;
        exp_n  = (lastpos > 0 && lastpos < DEPTH) ? lastpos : DEPTH;
        x      = (d < TO - 1) ? d : TO - 1;
        to_exp = (d > TO - 1);
        wr_obs.delete();
        @(posedge clk); #1 cmd_go = 1'b1;
        @(posedge clk); #1 cmd_go = 1'b0;
        @(negedge clk);
        check("go_busy", busy, 1);
        check("go_timeout_clr", timeout, 0);
        check("go_done_clr", done, 0);
        i = 0; guard = 0;
        while (i < exp_n) begin
            @(posedge clk); #1;
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = prog[i];
            load_last  = (i == lastpos - 1);
            cmd_go     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            check("load_rdy", load_ready, 1);
            if (load_valid && load_ready) i++;
            if (rst_mode == 1 && i == rst_at) begin do_reset(); return; end
            if (++guard > 300) begin check("load_guard", 32'(guard), 0); do_reset(); return; end
        end
        @(posedge clk); #1;
        cmd_go = 1'b0; done_in = 1'b0; load_valid = 1'b1; load_last = 1'b0;
        load_data = (i < prog.size()) ? prog[i] : 32'h0;
        @(negedge clk);
        check("last_imem_we", imem_we, 1);
        check("last_load_rdy", load_ready, 0);
        check("last_dp_start", dp_start, 0);
        check("last_busy", busy, 1);
        for (int rc = 1; rc <= x + 1; rc++) begin
            @(posedge clk); #1;
            load_valid = $urandom_range(0, 1);
            cmd_go     = ($urandom_range(0, 15) == 0);
            done_in    = (rc == d);
            @(negedge clk);
            if (rc == 1) begin
                check("run_imem_we", imem_we, 0);
                check("run_load_rdy", load_ready, 0);
            end
            if (rc <= x) begin
                check("run_dp_start", dp_start, 1);
                check("run_dump_vld", dump_valid, 0);
            end else begin
                check("exit_dp_start", dp_start, 0);
                check("exit_dump_vld", dump_valid, 1);
                check("exit_timeout", timeout, to_exp);
            end
        end
        b = 0; guard = 0; stall_left = 5;
        while (b < NB) begin
            @(posedge clk); #1;
            done_in = 1'b0; load_valid = 1'b0;
            cmd_go  = ($urandom_range(0, 15) == 0);
            if (b == stall_beat && stall_left > 0) begin
                dump_ready = 1'b0; stall_left--;
            end else begin
                dump_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            check("dump_vld", dump_valid, 1);
            if (b < 32) begin
                check("dump_ra", 32'(ra), 32'(b));
                check("dump_dat", dump_data, reg_base + 32'(b));
            end else begin
                check("dump_cycles", dump_data, 32'(x));
            end
            if (dump_ready && dump_valid) b++;
            if (rst_mode == 2 && b == rst_at) begin do_reset(); return; end
            if (++guard > 1000) begin check("dump_guard", 32'(guard), 0); do_reset(); return; end
        end
        @(posedge clk); #1 dump_ready = 1'b0; cmd_go = 1'b0;
        @(negedge clk);
        check("end_dump_vld", dump_valid, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_dp_start", dp_start, 0);
        check("end_timeout", timeout, to_exp);
        check("wr_count", 32'(wr_obs.size()), 32'(exp_n));
        for (int k = 0; k < exp_n && k < wr_obs.size(); k++) begin
            check("wr_addr", wr_obs[k].a, 32'(4 * k));
            check("wr_data", wr_obs[k].d, prog[k]);
        end
        @(negedge clk);
        check("done_hold", done, 1);
    endtask

    initial begin
        int lp, d, sb, mode, at, en, sel;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("init");
        rst_n = 1'b1;

        prog.delete();
        prog.push_back(32'h00500093); prog.push_back(32'h00A00113);
        prog.push_back(32'h002081B3); prog.push_back(32'h00000013);
        reg_base = 32'h100;
        run_episode(4, 20, 7, 0, 0);
        fill(10); run_episode(0, 5, -1, 0, 0);
        fill(2);  run_episode(1, TO + 10, 3, 0, 0);
        fill(3);  run_episode(3, TO - 1, -1, 0, 0);
        fill(5);  run_episode(5, 10, -1, 1, 2);
        fill(5);  run_episode(5, 10, -1, 2, 10);
        fill(3);  run_episode(2, 3, -1, 0, 0);

        for (int ep = 0; ep < 25; ep++) begin
            reg_base = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                lp = 0; fill(DEPTH + $urandom_range(1, 3));
            end else begin
                lp = $urandom_range(1, DEPTH + 2); fill(lp + 1);
            end
            en  = (lp > 0 && lp < DEPTH) ? lp : DEPTH;
            sel = $urandom_range(0, 4);
            d   = (sel == 0) ? TO - 1 : (sel == 1) ? TO : (sel == 2) ? TO - 2 : $urandom_range(1, TO + 4);
            sb  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 31);
            sel = $urandom_range(0, 9);
            mode = 0; at = 0;
            if (sel == 0 && en >= 2) begin mode = 1; at = $urandom_range(1, en - 1); end
            else if (sel == 1) begin mode = 2; at = $urandom_range(1, NB - 1); end
            run_episode(lp, d, sb, mode, at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter IMEM_DEPTH, default 256, maximum number of instruction words loaded per program.
REQ-002 Parameter TIMEOUT, default 65535, maximum RUN cycles before a forced stop.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 cmd_go  input  1  one-cycle request to load and run a program.
REQ-006 load_valid / load_ready / load_data / load_last  in/out/in/in  1/1/32/1  instruction stream; load_last marks the final word.
REQ-007 imem_we / imem_addr / imem_data  output  1/32/32  instruction-memory write port; imem_addr is a byte address.
REQ-008 dp_start  output  1  0 holds the datapath in load mode; 1 lets it run.
REQ-009 done_in  input  1  datapath completion flag.
REQ-010 ra / reg_data  out/in  5/32  register-file readback index and its combinational read data.
REQ-011 dump_valid / dump_ready / dump_data  out/in/out  1/1/32  result stream.
REQ-012 busy / done / timeout  output  1 each  status: not IDLE or DONE / in DONE / sticky timeout.

Function
REQ-013 States SHALL be IDLE, LOAD, RUN, DUMP and DONE.
REQ-014 IDLE or DONE, cmd_go=1: next state LOAD; word counter, imem_addr, cycle counter and timeout cleared.
REQ-015 cmd_go SHALL be ignored in LOAD, RUN and DUMP.
REQ-016 LOAD: load_ready=1; on each cycle with load_valid and load_ready both high, the next edge SHALL register imem_data=load_data, imem_addr=4*word_index and imem_we=1 for exactly one cycle.
REQ-017 LOAD SHALL exit to RUN on the accepted beat that has load_last=1 or that is word IMEM_DEPTH-1, whichever comes first; load_ready SHALL be 0 from the following cycle.
REQ-018 A single-beat load (load_last on the first beat) SHALL load one word and proceed to RUN.
REQ-019 dp_start SHALL be 1 only in RUN; it rises the cycle after the final imem_we pulse.
REQ-020 RUN: a 32-bit cycle counter SHALL increment once per cycle, starting at 0.
REQ-021 RUN, done_in=1: next state DUMP; dp_start falls on the same edge.
REQ-022 RUN, counter == TIMEOUT-1 with done_in=0: set timeout=1 and enter DUMP.
REQ-023 If done_in and the timeout condition occur in the same cycle, done_in SHALL win and timeout SHALL stay 0.
REQ-024 DUMP: ra=index (0..31), dump_valid=1, dump_data=reg_data; index SHALL advance only on dump_valid and dump_ready both high.
REQ-025 With dump_ready=0, ra and dump_data SHALL hold stable indefinitely.
REQ-026 DUMP exit SHALL occur after the final beat is accepted (index 31 without the macro); next state DONE, dump_valid=0.
REQ-027 DONE: done=1 until cmd_go is received.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and set every output to 0 (including dp_start, imem_we, load_ready, dump_valid and timeout) and every counter to 0, in any state.
REQ-029 After rst_n is released, the block SHALL await cmd_go; a program interrupted by reset SHALL NOT resume.

Configuration
REQ-030 Macro RUN_CYCLE_COUNT_EN defined: output cycle_count (32, the live RUN counter, frozen outside RUN) SHALL exist, and DUMP SHALL emit a 33rd beat carrying cycle_count after register 31.
REQ-031 Macro undefined: the cycle_count port SHALL be absent and DUMP SHALL emit exactly 32 beats.

Verification
REQ-032 Send cmd_go, then 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 (last on the 4th) -> imem_we pulses at addresses 0, 4, 8, 0xC with the same data, then dp_start=1 on the next cycle.
REQ-033 With IMEM_DEPTH=8, stream 10 words with no load_last -> 8 words written, load_ready=0 after the 8th, state RUN.
REQ-034 done_in asserted 20 cycles into RUN, model reg_data=0x100+ra, dump_ready always 1 -> 32 beats with data 0x100..0x11F, then done=1; with the macro, a 33rd beat of 20.
REQ-035 TIMEOUT=16, done_in never asserted -> dp_start falls after 16 RUN cycles, timeout=1, full dump follows; also drive done_in on cycle 16 -> timeout=0.
REQ-036 dump_ready low for 5 cycles on beat 7 -> ra=7 and dump_data stable for those 5 cycles, no beat lost or duplicated.
REQ-037 rst_n pulsed low mid-LOAD and again mid-DUMP -> all outputs 0 immediately, state IDLE, and cmd_go then restarts a clean load.
